// File: rtl/pattern_sequencer.sv
// pattern_sequencer: walks the pattern buffers at {bufp, fieldp}, presents each
// field byte on a valid/ready stream and pulses done at the end of the walk.
// Optional feature macro: PATSEQ_BYTE_COUNT_EN adds a saturating byte_count output.
//
// Handshake: data_out/data_valid are registered. A byte transfers on a rising
// edge where data_valid=1 and data_ready=1. Once data_valid rises, data_out is
// held unchanged until that transfer, or until halt/rst clears data_valid.
// Pointer-to-data latency is one cycle (FETCH registers field_byte).
module pattern_sequencer #(
  parameter int buffer_size  = 32,
  parameter int buffer_width = 8,
  parameter int num_buffers  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    halt,
  input  logic [4:0]              last_field,
  input  logic [2:0]              last_buf,
  input  logic                    loop,
  input  logic [buffer_width-1:0] field_byte,
  input  logic                    data_ready,
  output logic [2:0]              bufp,
  output logic [4:0]              fieldp,
  output logic                    incbufp,
  output logic                    incfieldp,
  output logic [buffer_width-1:0] data_out,
  output logic                    data_valid,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              state_dbg
`ifdef PATSEQ_BYTE_COUNT_EN
  ,
  output logic [15:0]             byte_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_ADVBUF  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Largest legal indices; requested limits above these are clamped at start.
  localparam logic [4:0] MAX_FIELD = 5'(buffer_size - 1);
  localparam logic [2:0] MAX_BUF   = 3'(num_buffers - 1);

  state_e                  state_q, state_d;
  logic [2:0]              bufp_q, bufp_d;
  logic [4:0]              fieldp_q, fieldp_d;
  logic [4:0]              last_field_q, last_field_d;
  logic [2:0]              last_buf_q, last_buf_d;
  logic [buffer_width-1:0] data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    incbufp_q, incbufp_d;
  logic                    incfieldp_q, incfieldp_d;
  logic                    handshake;
  logic                    field_more;
  logic                    buf_more;
`ifdef PATSEQ_BYTE_COUNT_EN
  logic [15:0]             byte_count_q, byte_count_d;
`endif

  // Transfer qualifier and end-of-buffer / end-of-sequence decisions.
  always_comb begin
    handshake  = (state_q == S_PRESENT) && data_valid_q && data_ready && !halt;
    field_more = (fieldp_q < last_field_q);
    buf_more   = (bufp_q < last_buf_q) || loop;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; halt overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_FETCH;
        S_FETCH:   state_d = S_PRESENT;
        S_PRESENT: begin
          if (handshake) begin
            if (field_more)    state_d = S_FETCH;
            else if (buf_more) state_d = S_ADVBUF;
            else               state_d = S_DONE;
          end
        end
        S_ADVBUF:  state_d = S_FETCH;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Datapath next values: limits, pointers, presented byte and pulses.
  always_comb begin
    bufp_d       = bufp_q;
    fieldp_d     = fieldp_q;
    last_field_d = last_field_q;
    last_buf_d   = last_buf_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    incbufp_d    = 1'b0;
    incfieldp_d  = 1'b0;
`ifdef PATSEQ_BYTE_COUNT_EN
    byte_count_d = byte_count_q;
`endif
    if (halt) begin
      data_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            last_field_d = (last_field > MAX_FIELD) ? MAX_FIELD : last_field;
            last_buf_d   = (last_buf > MAX_BUF) ? MAX_BUF : last_buf;
            bufp_d       = 3'd0;
            fieldp_d     = 5'd0;
`ifdef PATSEQ_BYTE_COUNT_EN
            byte_count_d = 16'd0;
`endif
          end
        end
        S_FETCH: begin
          data_out_d   = field_byte;
          data_valid_d = 1'b1;
        end
        S_PRESENT: begin
          if (handshake) begin
            data_valid_d = 1'b0;
`ifdef PATSEQ_BYTE_COUNT_EN
            if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
`endif
            if (field_more) begin
              fieldp_d    = fieldp_q + 5'd1;
              incfieldp_d = 1'b1;
            end else if (buf_more) begin
              fieldp_d = 5'd0;
            end
          end
        end
        S_ADVBUF: begin
          bufp_d    = (bufp_q == last_buf_q) ? 3'd0 : bufp_q + 3'd1;
          incbufp_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears every visible output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufp_q       <= 3'd0;
      fieldp_q     <= 5'd0;
      last_field_q <= 5'd0;
      last_buf_q   <= 3'd0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      incbufp_q    <= 1'b0;
      incfieldp_q  <= 1'b0;
    end else begin
      bufp_q       <= bufp_d;
      fieldp_q     <= fieldp_d;
      last_field_q <= last_field_d;
      last_buf_q   <= last_buf_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      incbufp_q    <= incbufp_d;
      incfieldp_q  <= incfieldp_d;
    end
  end

`ifdef PATSEQ_BYTE_COUNT_EN
  // Saturating count of transferred bytes since the last accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) byte_count_q <= 16'd0;
    else     byte_count_q <= byte_count_d;
  end

  assign byte_count = byte_count_q;
`endif

  assign bufp       = bufp_q;
  assign fieldp     = fieldp_q;
  assign incbufp    = incbufp_q;
  assign incfieldp  = incfieldp_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter buffer_size, default 32, meaning fields per buffer.
REQ-002 SHALL have parameter buffer_width, default 8, meaning bits per field byte.
REQ-003 SHALL have parameter num_buffers, default 8, meaning buffers addressable by bufp.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin sequence; sampled only in IDLE.
REQ-007 halt  input  1  abort; forces IDLE.
REQ-008 last_field  input  5  final field index per buffer; sampled at start.
REQ-009 last_buf  input  3  final buffer index; sampled at start.
REQ-010 loop  input  1  wrap to buffer 0 after last_buf; sampled each wrap decision.
REQ-011 field_byte  input  buffer_width  byte at {bufp,fieldp} from the pattern buffers (combinational read).
REQ-012 bufp  output  3  buffer pointer to the pattern buffers.
REQ-013 fieldp  output  5  field pointer to the pattern buffers.
REQ-014 incbufp  output  1  one-cycle pulse, bufp changed this cycle.
REQ-015 incfieldp  output  1  one-cycle pulse, fieldp incremented this cycle.
REQ-016 data_out  output  buffer_width  presented field byte.
REQ-017 data_valid  output  1  data_out valid.
REQ-018 data_ready  input  1  downstream accepts data_out.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 done  output  1  one-cycle pulse at sequence completion.

Function
REQ-021 States SHALL be IDLE, FETCH, PRESENT, ADVBUF, DONE.
REQ-022 IDLE: start=1 SHALL latch last_field (clamped to buffer_size-1) and last_buf (clamped to num_buffers-1), set bufp=0, fieldp=0, go FETCH.
REQ-023 FETCH: SHALL register field_byte into data_out, set data_valid=1, go PRESENT (one-cycle pointer-to-data latency).
REQ-024 PRESENT: data_out and data_valid SHALL hold stable until data_ready=1.
REQ-025 On handshake with fieldp<last_field: fieldp+1, incfieldp=1, data_valid=0, go FETCH.
REQ-026 On handshake with fieldp==last_field and (bufp<last_buf or loop=1): fieldp=0, data_valid=0, go ADVBUF.
REQ-027 On handshake with fieldp==last_field, bufp==last_buf, loop=0: data_valid=0, go DONE.
REQ-028 ADVBUF: bufp SHALL become 0 if bufp==last_buf, else bufp+1; incbufp=1; go FETCH.
REQ-029 bufp and fieldp SHALL never change in the same cycle; incbufp and incfieldp SHALL never both be 1.
REQ-030 DONE: done=1 for one cycle, go IDLE; pointers retain final values.
REQ-031 halt=1 in any state SHALL force IDLE next cycle with data_valid=0, no done pulse; halt has priority over start and handshake.
REQ-032 start while busy SHALL be ignored.
REQ-033 last_field=0 SHALL emit exactly one byte per buffer.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, bufp=0, fieldp=0, data_out=0, data_valid=0, incbufp=0, incfieldp=0, busy=0, done=0, including mid-sequence.

Configuration
REQ-035 Macro PATSEQ_BYTE_COUNT_EN defined: SHALL add output byte_count[15:0], cleared by rst and on accepted start, incremented on each data_valid&data_ready handshake, saturating at 16'hFFFF.
REQ-036 Macro undefined: byte_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 last_field=3, last_buf=1, loop=0, data_ready=1 constantly, field_byte=fieldp+16*bufp -> data_out 00,01,02,03,10,11,12,13 then done pulse; incfieldp x6, incbufp x1.
REQ-038 data_ready=0 for 5 cycles in PRESENT -> data_out and data_valid unchanged, no pointer change.
REQ-039 last_buf=2, loop=1 -> after buffer 2 field last_field, bufp wraps to 0 with incbufp=1, no done; halt then -> IDLE next cycle, done=0.
REQ-040 rst asserted mid-PRESENT -> all outputs zero same cycle, busy=0; start afterwards restarts at bufp=0, fieldp=0.
REQ-041 last_field=31, last_buf=7, loop=0 -> 256 bytes, incbufp and incfieldp never coincide; with PATSEQ_BYTE_COUNT_EN byte_count=256.
